// File: rtl/ecko_cnn_pkg.sv
// Shared CNN definitions: activation width, pool FSM state
// encoding and the (row, col, filter) frame packing offset.
package ecko_cnn_pkg;

   localparam int ACTIV_BITS_DEF = 8;

   typedef logic [0:0] pool_state_t;
   localparam pool_state_t ST_IDLE = 1'b0;
   localparam pool_state_t ST_POOL = 1'b1;

   function automatic int unsigned frame_off(
      input int unsigned row,
      input int unsigned col,
      input int unsigned filt,
      input int unsigned width,
      input int unsigned nfilt,
      input int unsigned abits
   );
      return ((row * width + col) * nfilt + filt) * abits;
   endfunction

endpackage

// File: rtl/maxpool2d_if.sv
// Frame in/out bundle for maxpool2d; drop_count exists only
// when MAXPOOL2D_DROP_CNT_EN is defined.
interface maxpool2d_if
   import ecko_cnn_pkg::*;
#(
   parameter int INPUT_WIDTH  = 32,
   parameter int INPUT_HEIGHT = 1,
   parameter int NUM_FILTERS  = 8,
   parameter int POOL_SIZE    = 2,
   parameter int ACTIV_BITS   = ACTIV_BITS_DEF
);
   localparam int OUT_WIDTH = INPUT_WIDTH / POOL_SIZE;
   localparam int IN_BITS =
      INPUT_WIDTH * INPUT_HEIGHT * NUM_FILTERS * ACTIV_BITS;
   localparam int OUT_BITS =
      OUT_WIDTH * INPUT_HEIGHT * NUM_FILTERS * ACTIV_BITS;

   logic [IN_BITS-1:0]  data_in;
   logic                data_valid;
   logic [OUT_BITS-1:0] data_out;
   logic                data_out_valid;
   logic                busy;
`ifdef MAXPOOL2D_DROP_CNT_EN
   logic [7:0]          drop_count;
`endif

   modport master (
      output data_in, data_valid,
`ifdef MAXPOOL2D_DROP_CNT_EN
      input  drop_count,
`endif
      input  data_out, data_out_valid, busy
   );

   modport slave (
      input  data_in, data_valid,
`ifdef MAXPOOL2D_DROP_CNT_EN
      output drop_count,
`endif
      output data_out, data_out_valid, busy
   );

endinterface

// File: rtl/maxpool2d_pool_max.sv
// Combinational unsigned max over one POOL_SIZE-wide window.
module pool_max #(
   parameter int POOL_SIZE  = 2,
   parameter int ACTIV_BITS = 8
) (
   input  logic [POOL_SIZE-1:0][ACTIV_BITS-1:0] win_i,
   output logic [ACTIV_BITS-1:0]                max_o
);

   always_comb begin
      max_o = win_i[0];
      for (int p = 1; p < POOL_SIZE; p++) begin
         if (win_i[p] > max_o) max_o = win_i[p];
      end
   end

endmodule

// File: rtl/maxpool2d.sv
// Width-axis max-pool: latch a frame, emit one pooled column per
// cycle. Optional drop counter: MAXPOOL2D_DROP_CNT_EN.
module maxpool2d
   import ecko_cnn_pkg::*;
#(
   parameter int INPUT_WIDTH  = 32,
   parameter int INPUT_HEIGHT = 1,
   parameter int NUM_FILTERS  = 8,
   parameter int POOL_SIZE    = 2,
   parameter int ACTIV_BITS   = ACTIV_BITS_DEF
) (
   input logic        clk,
   input logic        rst,
   maxpool2d_if.slave bus
);

   localparam int OW = INPUT_WIDTH / POOL_SIZE;
   localparam int IW =
      (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
   localparam int CW = (OW > 1) ? $clog2(OW) : 1;

   typedef logic [INPUT_HEIGHT-1:0][INPUT_WIDTH-1:0]
      [NUM_FILTERS-1:0][ACTIV_BITS-1:0] frame_t;
   typedef logic [INPUT_HEIGHT-1:0][OW-1:0]
      [NUM_FILTERS-1:0][ACTIV_BITS-1:0] oframe_t;

   frame_t      frame_q, frame_d;
   oframe_t     obuf_q, obuf_d;
   oframe_t     dout_q, dout_d;
   pool_state_t state_q, state_d;
   logic [CW-1:0] c_q, c_d;
   logic        vld_q, vld_d;
   logic        last;
   logic [IW-1:0] idx;

   logic [INPUT_HEIGHT-1:0][NUM_FILTERS-1:0]
      [POOL_SIZE-1:0][ACTIV_BITS-1:0] win;
   logic [INPUT_HEIGHT-1:0][NUM_FILTERS-1:0]
      [ACTIV_BITS-1:0] colmax;

   assign last = (state_q == ST_POOL) &&
                 (c_q == CW'(OW - 1));

   // gather the input window for output column c_q
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = 0; i < INPUT_HEIGHT; i++) begin
         for (int k = 0; k < NUM_FILTERS; k++) begin
            for (int p = 0; p < POOL_SIZE; p++) begin
               idx = IW'(int'(c_q) * POOL_SIZE + p);
               win[i][k][p] = frame_q[i][idx][k];
            end
         end
      end
   end

   for (genvar gi = 0; gi < INPUT_HEIGHT; gi++) begin : g_row
      for (genvar gk = 0; gk < NUM_FILTERS; gk++) begin : g_flt
         pool_max #(
            .POOL_SIZE  (POOL_SIZE),
            .ACTIV_BITS (ACTIV_BITS)
         ) u_max (
            .win_i (win[gi][gk]),
            .max_o (colmax[gi][gk])
         );
      end
   end

   always_comb begin
      obuf_d = obuf_q;
      if (state_q == ST_POOL) begin
         for (int i = 0; i < INPUT_HEIGHT; i++) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
               obuf_d[i][c_q][k] = colmax[i][k];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      frame_d = frame_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (bus.data_valid) begin
               frame_d = bus.data_in;
               c_d     = '0;
               state_d = ST_POOL;
            end
         end
         (state_q == ST_POOL): begin
            if (last) begin
               dout_d  = obuf_d;
               vld_d   = 1'b1;
               c_d     = '0;
               state_d = ST_IDLE;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         frame_q <= '0;
         obuf_q  <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         frame_q <= frame_d;
         obuf_q  <= obuf_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
      end
   end

`ifdef MAXPOOL2D_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   // saturating count of frames offered while busy
   always_comb begin
      drop_d = drop_q;
      if ((state_q == ST_POOL) && bus.data_valid &&
          (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   assign bus.drop_count = drop_q;
`endif

   assign bus.data_out       = dout_q;
   assign bus.data_out_valid = vld_q;
   assign bus.busy           = (state_q == ST_POOL);

endmodule
